// File: rtl/dcache_port_merger_if.sv
// Bundle of LSU request ports, translation hand-off, dcache lanes and responses.
// The master modport is the surrounding pipeline and cache; the slave is the merger.
interface dcache_port_merger_if #(
    parameter int unsigned NPORTS       = 2,
    parameter int unsigned TAG_WIDTH    = 20,
    parameter int unsigned INDEX_WIDTH  = 8,
    parameter int unsigned OFFSET_WIDTH = 4
);
    // LSU side
    logic [NPORTS-1:0]              req_valid;
    logic [32*NPORTS-1:0]           req_va;
    logic [NPORTS-1:0]              req_we;
    logic [2*NPORTS-1:0]            req_size;
    logic [4*NPORTS-1:0]            req_wstrb;
    logic [32*NPORTS-1:0]           req_wdata;
    logic                           cancel;
    logic [NPORTS-1:0]              port_addr_ok;
    logic [NPORTS-1:0]              port_excp;
    logic [NPORTS-1:0]              port_data_ok;
    logic [32*NPORTS-1:0]           port_rdata;
    // Translation side
    logic [TAG_WIDTH-1:0]           xlate_vtag;
    logic [TAG_WIDTH-1:0]           xlate_ptag;
    logic [1:0]                     xlate_mat;
    logic                           xlate_fault;
    // Dcache side
    logic [NPORTS-1:0]              dc_valid;
    logic [2:0]                     dc_op;
    logic [TAG_WIDTH-1:0]           dc_tag;
    logic [INDEX_WIDTH-1:0]         dc_index;
    logic [OFFSET_WIDTH*NPORTS-1:0] dc_offset;
    logic [4*NPORTS-1:0]            dc_wstrb;
    logic [32*NPORTS-1:0]           dc_wdata;
    logic [2*NPORTS-1:0]            dc_size;
    logic                           dc_uncached;
    logic                           dc_addr_ok;
    logic                           dc_data_ok;
    logic [32*NPORTS-1:0]           dc_rdata;
    logic                           protocol_err;

    modport master (
        output req_valid, req_va, req_we, req_size, req_wstrb, req_wdata, cancel,
        input  port_addr_ok, port_excp, port_data_ok, port_rdata,
        input  xlate_vtag,
        output xlate_ptag, xlate_mat, xlate_fault,
        input  dc_valid, dc_op, dc_tag, dc_index, dc_offset, dc_wstrb, dc_wdata, dc_size,
        input  dc_uncached,
        output dc_addr_ok, dc_data_ok, dc_rdata,
        input  protocol_err
    );

    modport slave (
        input  req_valid, req_va, req_we, req_size, req_wstrb, req_wdata, cancel,
        output port_addr_ok, port_excp, port_data_ok, port_rdata,
        output xlate_vtag,
        input  xlate_ptag, xlate_mat, xlate_fault,
        output dc_valid, dc_op, dc_tag, dc_index, dc_offset, dc_wstrb, dc_wdata, dc_size,
        output dc_uncached,
        input  dc_addr_ok, dc_data_ok, dc_rdata,
        output protocol_err
    );
endinterface

// File: rtl/dcache_port_merger.sv
// Merges the oldest LSU request with younger same-line requests into one multi-lane
// dcache access and routes completions back through an in-order tracker FIFO.
module dcache_port_merger #(
    parameter int unsigned NPORTS          = 2,
    parameter int unsigned TAG_WIDTH       = 20,
    parameter int unsigned INDEX_WIDTH     = 8,
    parameter int unsigned OFFSET_WIDTH    = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic                 clk,
    input logic                 reset,
    dcache_port_merger_if.slave bus
);
    localparam int unsigned LineW = 32 - OFFSET_WIDTH;
    localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);

    logic [NPORTS-1:0] lead_oh;
    logic [NPORTS-1:0] joined;
    logic [LineW-1:0]  lead_line;
    logic              lead_we;
    logic              cached;
    logic              full;
    logic              empty;
    logic              issue_ok;
    logic              push;
    logic              pop;
    logic              head_live;

    logic [NPORTS-1:0] mask_q    [MAX_OUTSTANDING];
    logic [NPORTS-1:0] mask_d    [MAX_OUTSTANDING];
    logic              dropped_q [MAX_OUTSTANDING];
    logic              dropped_d [MAX_OUTSTANDING];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              protocol_err_q, protocol_err_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cached = (bus.xlate_mat != 2'd0);

    // Pick the oldest valid port as lead, then extend the group in order until a port
    // fails to join; a port that cannot join blocks everything younger.
    always_comb begin
        logic found;
        logic scanning;
        logic store_seen;
        lead_oh    = '0;
        joined     = '0;
        lead_line  = '0;
        lead_we    = 1'b0;
        found      = 1'b0;
        scanning   = 1'b0;
        store_seen = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && bus.req_valid[i]) begin
                found      = 1'b1;
                scanning   = 1'b1;
                lead_oh[i] = 1'b1;
                joined[i]  = 1'b1;
                lead_line  = bus.req_va[32*i+OFFSET_WIDTH +: LineW];
                lead_we    = bus.req_we[i];
                store_seen = bus.req_we[i];
            end else if (scanning) begin
                if (bus.req_valid[i] && cached
                        && (bus.req_va[32*i+OFFSET_WIDTH +: LineW] == lead_line)
                        && !(bus.req_we[i] && store_seen)) begin
                    joined[i]  = 1'b1;
                    store_seen = store_seen | bus.req_we[i];
                end else begin
                    scanning = 1'b0;
                end
            end
        end
    end

    // A full tracker may still issue when the head retires in the same cycle.
    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(MAX_OUTSTANDING));
    assign issue_ok = !bus.cancel && !bus.xlate_fault && (!full || bus.dc_data_ok);
    assign push     = (|bus.dc_valid) && bus.dc_addr_ok;
    assign pop      = bus.dc_data_ok && !empty;

    assign bus.dc_valid     = joined & {NPORTS{issue_ok}};
    assign bus.port_addr_ok = bus.dc_valid & {NPORTS{bus.dc_addr_ok}};
    assign bus.port_excp    = lead_oh & {NPORTS{bus.xlate_fault && !bus.cancel}};
    assign bus.xlate_vtag   = lead_line[LineW-1 -: TAG_WIDTH];
    assign bus.dc_op        = {2'b00, lead_we};
    assign bus.dc_tag       = bus.xlate_ptag;
    assign bus.dc_index     = lead_line[INDEX_WIDTH-1:0];
    assign bus.dc_wstrb     = bus.req_wstrb;
    assign bus.dc_wdata     = bus.req_wdata;
    assign bus.dc_size      = bus.req_size;
    assign bus.dc_uncached  = !cached;

    // Per-lane line offsets come straight from each port's address.
    always_comb begin
        bus.dc_offset = '0;
        for (int i = 0; i < NPORTS; i++) begin
            bus.dc_offset[OFFSET_WIDTH*i +: OFFSET_WIDTH] = bus.req_va[32*i +: OFFSET_WIDTH];
        end
    end

    // Completions go to the head's lanes unless the head was flushed or a flush is live.
    assign head_live        = bus.dc_data_ok && !empty && !dropped_q[rd_ptr_q] && !bus.cancel;
    assign bus.port_data_ok = mask_q[rd_ptr_q] & {NPORTS{head_live}};
    assign bus.port_rdata   = bus.dc_rdata;
    assign bus.protocol_err = protocol_err_q;

    // Tracker next state: flush marking, push/pop, occupancy and sticky error.
    always_comb begin
        mask_d         = mask_q;
        dropped_d      = dropped_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        protocol_err_d = protocol_err_q;
        // Marking free slots too is harmless: a push always clears its slot.
        if (bus.cancel) begin
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                dropped_d[k] = 1'b1;
            end
        end
        if (push) begin
            mask_d[wr_ptr_q]    = bus.dc_valid;
            dropped_d[wr_ptr_q] = 1'b0;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (bus.dc_data_ok && empty) begin
            protocol_err_d = 1'b1;
        end
    end

    // Tracker state register; reset drops every in-flight entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            protocol_err_q <= 1'b0;
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                mask_q[k]    <= '0;
                dropped_q[k] <= 1'b0;
            end
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            protocol_err_q <= protocol_err_d;
            mask_q         <= mask_d;
            dropped_q      <= dropped_d;
        end
    end
endmodule
